// File: rtl/f1_delay_seq.sv
// rtl/f1_delay_seq.sv - start-light sequencer: lamps one per tick, random hold-off, then all out
module f1_delay_seq #(
    parameter int N_LIGHTS = 8,
    parameter int DELAY_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic                abort,
    input  logic                tick,
    input  logic [7:0]          lfsr_data,
    output logic                lfsr_en,
    output logic [N_LIGHTS-1:0] lights,
    output logic                busy,
    output logic                delay_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LIGHTS = 2'd1,
        DELAY  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [N_LIGHTS-1:0] lights_nx;
    logic [DELAY_W-1:0]  cnt, cnt_nx;
    logic [DELAY_W-1:0]  seed;
    logic                done_nx;

    assign seed = lfsr_data[DELAY_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lights     <= '0;
            cnt        <= '0;
            delay_done <= 1'b0;
        end else begin
            state      <= state_nx;
            lights     <= lights_nx;
            cnt        <= cnt_nx;
            delay_done <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        lights_nx = lights;
        cnt_nx    = cnt;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                lights_nx = '0;
                cnt_nx    = '0;
                if (trigger) state_nx = LIGHTS;
            end
            LIGHTS: begin
                if (abort) begin
                    lights_nx = '0;
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                end else if (tick) begin
                    lights_nx = {lights[N_LIGHTS-2:0], 1'b1};
                    if (lights[N_LIGHTS-2]) begin
                        // a zero seed still gives a one-tick hold-off, never a wrap
                        cnt_nx   = (seed == '0) ? DELAY_W'(1) : seed;
                        state_nx = DELAY;
                    end
                end
            end
            DELAY: begin
                if (abort) begin
                    lights_nx = '0;
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                end else if (tick) begin
                    cnt_nx = cnt - DELAY_W'(1);
                    if (cnt == DELAY_W'(1)) begin
                        lights_nx = '0;
                        done_nx   = 1'b1;
                        state_nx  = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // LFSR runs while waiting or lighting and freezes once the hold-off is captured
    assign lfsr_en = (state == IDLE) || (state == LIGHTS);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_f1_delay_seq.sv
// tb/tb_f1_delay_seq.sv - self-checking bench for f1_delay_seq
module tb_f1_delay_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tr_a, ab_a, tk_a;
    logic [7:0] ld_a;
    logic       en_a, busy_a, done_a;
    logic [7:0] lights_a;
    logic       tr_b, ab_b, tk_b;
    logic [7:0] ld_b;
    logic       en_b, busy_b, done_b;
    logic [3:0] lights_b;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    f1_delay_seq u_a (
        .clk(clk), .rst_n(rst_n), .trigger(tr_a), .abort(ab_a), .tick(tk_a),
        .lfsr_data(ld_a), .lfsr_en(en_a), .lights(lights_a), .busy(busy_a),
        .delay_done(done_a)
    );

    f1_delay_seq #(.N_LIGHTS(4), .DELAY_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .trigger(tr_b), .abort(ab_b), .tick(tk_b),
        .lfsr_data(ld_b), .lfsr_en(en_b), .lights(lights_b), .busy(busy_b),
        .delay_done(done_b)
    );

    typedef struct {
        logic       tr, ab, tk;
        logic [7:0] ld;
        logic [3:0] lights;
        logic       busy, done, en;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic step(input logic tr, input logic ab, input logic tk, input logic [7:0] ld);
        tr_a = tr; ab_a = ab; tk_a = tk; ld_a = ld;
        @(posedge clk);
        #1;
    endtask

    // delay_done pulses are matched against the cycles the stimulus predicted
    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delay_done", 32'(cyc_n), 32'hFFFF_FFFF);
            end else begin
                chk("delay_done_cycle", 32'(cyc_n), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_seq(input logic [7:0] seed, input int gap, input logic noisy);
        int d, n;
        logic [7:0] exp_l;
        d = (seed == 8'd0) ? 1 : int'(seed);
        n = 8 + d;
        step(1'b1, 1'b0, 1'b0, seed);
        chk("start_busy", 32'(busy_a), 32'd1);
        chk("start_lights", 32'(lights_a), 32'd0);
        for (int k = 1; k <= n; k++) begin
            if (k == n) exp_q.push_back(cyc_n + 1);
            step(noisy, 1'b0, 1'b1, seed);
            if (k < 8)      exp_l = 8'((1 << k) - 1);
            else if (k < n) exp_l = 8'hFF;
            else            exp_l = 8'h00;
            chk("seq_lights", 32'(lights_a), 32'(exp_l));
            chk("seq_lfsr_en", 32'(en_a), (k < 8) ? 32'd1 : 32'd0);
            if (k < n) repeat (gap) step(1'b0, 1'b0, 1'b0, seed);
        end
        step(noisy, 1'b0, 1'b0, seed);
        chk("end_busy", 32'(busy_a), 32'd0);
        chk("end_lfsr_en", 32'(en_a), 32'd1);
        chk("end_lights", 32'(lights_a), 32'd0);
        step(1'b0, 1'b0, 1'b0, seed);
        chk("idle_after_busy", 32'(busy_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           tr    ab    tk    ld     lights busy  done  en
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'hA3, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'hA3, 4'h1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'hA3, 4'h3, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'hA3, 4'h3, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'hA3, 4'h7, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hA3, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        tr_a = 0; ab_a = 0; tk_a = 0; ld_a = 8'h00;
        tr_b = 0; ab_b = 0; tk_b = 0; ld_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lights", 32'(lights_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_lfsr_en", 32'(en_a), 32'd1);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // small instance: table of per-cycle vectors
        for (int i = 0; i < 11; i++) begin
            tr_b = vecs[i].tr; ab_b = vecs[i].ab; tk_b = vecs[i].tk; ld_b = vecs[i].ld;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_lights", i), 32'(lights_b), 32'(vecs[i].lights));
            chk($sformatf("vec%0d_busy", i), 32'(busy_b), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done_b), 32'(vecs[i].done));
            chk($sformatf("vec%0d_lfsr_en", i), 32'(en_b), 32'(vecs[i].en));
        end
        tr_b = 0; ab_b = 0; tk_b = 0;

        run_seq(8'h05, 3, 1'b0);
        run_seq(8'h00, 0, 1'b0);
        run_seq(8'hFF, 0, 1'b0);
        run_seq(8'h02, 0, 1'b1);

        // abort together with a tick while cnt==3
        step(1'b1, 1'b0, 1'b0, 8'h05);
        for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 1'b1, 8'h05);
        chk("pre_abort_lights", 32'(lights_a), 32'hFF);
        step(1'b0, 1'b1, 1'b1, 8'h05);
        chk("abort_lights", 32'(lights_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_lfsr_en", 32'(en_a), 32'd1);
        repeat (4) step(1'b0, 1'b0, 1'b1, 8'h05);
        chk("abort_stays_idle", 32'(busy_a), 32'd0);

        // trigger held high: restart after exactly one IDLE cycle
        step(1'b1, 1'b0, 1'b0, 8'h01);
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) exp_q.push_back(cyc_n + 1);
            step(1'b1, 1'b0, 1'b1, 8'h01);
        end
        chk("b2b_done_lights", 32'(lights_a), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h01);
        chk("b2b_idle_gap", 32'(busy_a), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h01);
        chk("b2b_restart", 32'(busy_a), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        chk("b2b_abort", 32'(busy_a), 32'd0);

        // reset mid-LIGHTS
        step(1'b1, 1'b0, 1'b0, 8'h33);
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'h33);
        chk("pre_reset_lights", 32'(lights_a), 32'h07);
        rst_n = 1'b0;
        #1;
        chk("async_rst_lights", 32'(lights_a), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b1, 8'h33);
            chk("rst_mid_lights", 32'(lights_a), 32'd0);
            chk("rst_mid_busy", 32'(busy_a), 32'd0);
            chk("rst_mid_done", 32'(done_a), 32'd0);
            chk("rst_mid_lfsr_en", 32'(en_a), 32'd1);
        end
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'h33);
        chk("post_reset_idle", 32'(busy_a), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
